// File: rtl/baser_257b_transcoder.sv
// baser_257b_transcoder: groups four 64b/66b blocks into one 256b/257b transmit block.
// Define BASER_257B_TX_COUNTERS_EN to implement the block/data/ctrl/invalid-header counters.
module baser_257b_transcoder #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH = 2,
    parameter int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH,
    parameter int TC_DATA_WIDTH = 4 * DATA_WIDTH,
    parameter int TC_HDR_WIDTH = 1,
    parameter int TC_WIDTH = TC_DATA_WIDTH + TC_HDR_WIDTH,
    parameter logic [6:0] CTRL_CHAR_PATTERN = 7'h1E
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [FRAME_WIDTH-1:0] i_tx_coded,
    output logic [TC_WIDTH-1:0]    o_tx_xcoded,
    output logic                   o_valid,
    output logic [31:0]            o_block_count,
    output logic [31:0]            o_data_count,
    output logic [31:0]            o_ctrl_count,
    output logic [31:0]            o_inv_sh_count
);
    localparam logic [7:0] ERR_TYPE = 8'h1E;
    logic [1:0]                  idx_q, idx_d;
    logic [2:0][DATA_WIDTH-1:0]  pay_q;
    logic [2:0]                  flag_q;
    logic [TC_WIDTH-1:0]         xcoded_q, xcoded_d;
    logic                        valid_q;
    logic [HDR_WIDTH-1:0]        sh;
    logic                        inv, in_flag, fire, all_data, first;
    logic [DATA_WIDTH-1:0]       in_pay;
    logic [3:0][DATA_WIDTH-1:0]  pays;
    logic [3:0]                  f;
    logic [TC_DATA_WIDTH-1:0]    body;
    logic [8:0]                  pos;

    assign sh       = i_tx_coded[FRAME_WIDTH-1 -: HDR_WIDTH];
    assign inv      = (sh == 2'b00) || (sh == 2'b11);
    assign in_flag  = (sh == 2'b01);
    assign in_pay   = inv ? {{8{CTRL_CHAR_PATTERN}}, ERR_TYPE} : i_tx_coded[DATA_WIDTH-1:0];
    assign fire     = i_valid && (idx_q == 2'd3);
    assign idx_d    = i_valid ? idx_q + 2'd1 : idx_q;
    assign pays     = {in_pay, pay_q};
    assign f        = {in_flag, flag_q};
    assign all_data = &f;

    // Control layout: flags, then payloads in block order; the first control block drops its type's high nibble.
    always_comb begin
        body  = TC_DATA_WIDTH'(f);
        pos   = 9'd4;
        first = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!f[i] && first) begin
                body  = body | (TC_DATA_WIDTH'({pays[i][DATA_WIDTH-1:8], pays[i][3:0]}) << pos);
                pos   = pos + 9'd60;
                first = 1'b0;
            end else begin
                body = body | (TC_DATA_WIDTH'(pays[i]) << pos);
                pos  = pos + 9'd64;
            end
        end
        xcoded_d = all_data ? {pays, TC_HDR_WIDTH'(1)} : {body, TC_HDR_WIDTH'(0)};
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q    <= '0;
            pay_q    <= '0;
            flag_q   <= '0;
            xcoded_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= fire;
            for (int i = 0; i < 3; i++) begin
                if (i_valid && idx_q == 2'(i)) begin
                    pay_q[i]  <= in_pay;
                    flag_q[i] <= in_flag;
                end
            end
            if (fire) xcoded_q <= xcoded_d;
        end
    end

    assign o_tx_xcoded = xcoded_q;
    assign o_valid     = valid_q;

`ifdef BASER_257B_TX_COUNTERS_EN
    logic [31:0] blk_q, data_q, ctrl_q, inv_q;
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            blk_q  <= '0;
            data_q <= '0;
            ctrl_q <= '0;
            inv_q  <= '0;
        end else begin
            if (fire) blk_q <= blk_q + 32'd1;
            if (fire && all_data) data_q <= data_q + 32'd1;
            if (fire && !all_data) ctrl_q <= ctrl_q + 32'd1;
            if (i_valid && inv) inv_q <= inv_q + 32'd1;
        end
    end
    assign o_block_count  = blk_q;
    assign o_data_count   = data_q;
    assign o_ctrl_count   = ctrl_q;
    assign o_inv_sh_count = inv_q;
`else
    assign o_block_count  = '0;
    assign o_data_count   = '0;
    assign o_ctrl_count   = '0;
    assign o_inv_sh_count = '0;
`endif
endmodule

// File: tb/tb_baser_257b_transcoder.sv
// tb_baser_257b_transcoder: directed checks of 257b encoding, latency, gaps, reset and counters.
module tb_baser_257b_transcoder;
    logic         clk = 1'b0;
    logic         i_rst = 1'b0;
    logic         i_valid = 1'b0;
    logic [65:0]  i_tx_coded = '0;
    logic [256:0] o_tx_xcoded;
    logic         o_valid;
    logic [31:0]  o_block_count, o_data_count, o_ctrl_count, o_inv_sh_count;
    int total = 0;
    int bad = 0;
    int e_blk = 0, e_data = 0, e_ctrl = 0, e_inv = 0;
`ifdef BASER_257B_TX_COUNTERS_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif
    localparam logic [63:0] AA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [65:0] DAA = {2'b01, AA};
    logic [65:0]  blk [4];
    logic [256:0] exp_x;

    always #5 clk = ~clk;

    baser_257b_transcoder dut (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_tx_coded(i_tx_coded),
        .o_tx_xcoded(o_tx_xcoded), .o_valid(o_valid), .o_block_count(o_block_count),
        .o_data_count(o_data_count), .o_ctrl_count(o_ctrl_count), .o_inv_sh_count(o_inv_sh_count)
    );

    function automatic logic [31:0] ec(input int n);
        return CNT ? 32'(n) : 32'd0;
    endfunction

    task automatic send(input logic [65:0] b);
        i_valid = 1'b1;
        i_tx_coded = b;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_group();
        for (int i = 0; i < 4; i++) send(blk[i]);
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        #3;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        total++; if (o_tx_xcoded !== '0) begin bad++; $display("FAIL reset_x got=%h want=0", o_tx_xcoded); end
        total++; if (o_block_count !== 0 || o_data_count !== 0) begin bad++; $display("FAIL reset_cnt1 got=%0d/%0d want=0/0", o_block_count, o_data_count); end
        total++; if (o_ctrl_count !== 0 || o_inv_sh_count !== 0) begin bad++; $display("FAIL reset_cnt2 got=%0d/%0d want=0/0", o_ctrl_count, o_inv_sh_count); end
        @(negedge clk);
        i_rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_data();
        for (int i = 0; i < 4; i++) blk[i] = DAA;
        for (int i = 0; i < 3; i++) begin
            send(blk[i]);
            total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL data_early_valid blk=%0d got=%b want=0", i, o_valid); end
        end
        send(blk[3]);
        e_blk++; e_data++;
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL data_valid got=%b want=1", o_valid); end
        total++; if (o_tx_xcoded !== {{32{8'hAA}}, 1'b1}) begin bad++; $display("FAIL data_x got=%h want=%h", o_tx_xcoded, {{32{8'hAA}}, 1'b1}); end
        total++; if (o_block_count !== ec(e_blk) || o_data_count !== ec(e_data)) begin bad++; $display("FAIL data_cnt got=%0d/%0d want=%0d/%0d", o_block_count, o_data_count, ec(e_blk), ec(e_data)); end
        @(posedge clk);
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL strobe_len got=%b want=0", o_valid); end
        total++; if (o_tx_xcoded !== {{32{8'hAA}}, 1'b1}) begin bad++; $display("FAIL hold_x got=%h", o_tx_xcoded); end
    endtask

    task automatic test_ctrl_first();
        blk[0] = {2'b10, {7{8'hAA}}, 8'h78};
        for (int i = 1; i < 4; i++) blk[i] = DAA;
        send_group();
        e_blk++; e_ctrl++;
        exp_x = {{31{8'hAA}}, 4'h8, 4'b1110, 1'b0};
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL c0_valid got=%b want=1", o_valid); end
        total++; if (o_tx_xcoded !== exp_x) begin bad++; $display("FAIL c0_x got=%h want=%h", o_tx_xcoded, exp_x); end
        total++; if (o_ctrl_count !== ec(e_ctrl) || o_data_count !== ec(e_data)) begin bad++; $display("FAIL c0_cnt got=%0d/%0d want=%0d/%0d", o_ctrl_count, o_data_count, ec(e_ctrl), ec(e_data)); end
    endtask

    task automatic test_mixed();
        blk[0] = DAA;
        blk[1] = {2'b10, {7{8'hAA}}, 8'hFF};
        blk[2] = DAA;
        blk[3] = {2'b10, {8{7'h1E}}, 8'h87};
        send_group();
        e_blk++; e_ctrl++;
        exp_x = {{8{7'h1E}}, 8'h87, AA, {7{8'hAA}}, 4'hF, AA, 4'b0101, 1'b0};
        total++; if (o_tx_xcoded !== exp_x) begin bad++; $display("FAIL mix_x got=%h want=%h", o_tx_xcoded, exp_x); end
        total++; if (o_tx_xcoded[200:193] !== 8'h87 || o_tx_xcoded[72:69] !== 4'hF) begin bad++; $display("FAIL mix_fields got=%h/%h want=87/f", o_tx_xcoded[200:193], o_tx_xcoded[72:69]); end
        total++; if (o_ctrl_count !== ec(e_ctrl) || o_block_count !== ec(e_blk)) begin bad++; $display("FAIL mix_cnt got=%0d/%0d want=%0d/%0d", o_ctrl_count, o_block_count, ec(e_ctrl), ec(e_blk)); end
    endtask

    task automatic test_invalid_sh();
        blk[0] = DAA;
        blk[1] = DAA;
        blk[2] = {2'b11, 64'h5555_5555_5555_5555};
        blk[3] = DAA;
        send_group();
        e_blk++; e_ctrl++; e_inv++;
        exp_x = {AA, {8{7'h1E}}, 4'hE, AA, AA, 4'b1011, 1'b0};
        total++; if (o_tx_xcoded !== exp_x) begin bad++; $display("FAIL inv_x got=%h want=%h", o_tx_xcoded, exp_x); end
        total++; if (o_inv_sh_count !== ec(e_inv)) begin bad++; $display("FAIL inv_cnt got=%0d want=%0d", o_inv_sh_count, ec(e_inv)); end
        send({2'b00, AA});
        e_inv++;
        total++; if (o_inv_sh_count !== ec(e_inv)) begin bad++; $display("FAIL inv_cnt00 got=%0d want=%0d", o_inv_sh_count, ec(e_inv)); end
        for (int i = 0; i < 3; i++) send(DAA);
        e_blk++; e_ctrl++;
        exp_x = {AA, AA, AA, {8{7'h1E}}, 4'hE, 4'b1110, 1'b0};
        total++; if (o_tx_xcoded !== exp_x) begin bad++; $display("FAIL inv00_x got=%h want=%h", o_tx_xcoded, exp_x); end
    endtask

    task automatic test_gaps();
        blk[0] = {2'b01, 64'h0123_4567_89AB_CDEF};
        blk[1] = {2'b01, 64'h1111_2222_3333_4444};
        blk[2] = {2'b01, 64'hDEAD_BEEF_0BAD_F00D};
        blk[3] = {2'b10, 64'hFEDC_BA98_7654_322D};
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < i; g++) begin
                @(posedge clk);
                #1;
                total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL gap_valid blk=%0d got=%b want=0", i, o_valid); end
            end
            send(blk[i]);
        end
        e_blk++; e_ctrl++;
        exp_x = {56'hFEDC_BA98_7654_32, 4'hD, 64'hDEAD_BEEF_0BAD_F00D, 64'h1111_2222_3333_4444, 64'h0123_4567_89AB_CDEF, 4'b0111, 1'b0};
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL gap_valid4 got=%b want=1", o_valid); end
        total++; if (o_tx_xcoded !== exp_x) begin bad++; $display("FAIL gap_x got=%h want=%h", o_tx_xcoded, exp_x); end
    endtask

    task automatic test_reset_mid();
        send({2'b10, 64'h0});
        send({2'b11, 64'h0});
        i_rst = 1'b1;
        #2;
        e_blk = 0; e_data = 0; e_ctrl = 0; e_inv = 0;
        @(negedge clk);
        i_rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (o_block_count !== 0 || o_inv_sh_count !== 0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", o_block_count, o_inv_sh_count); end
        blk[0] = {2'b01, 64'h0000_0000_0000_0001};
        blk[1] = {2'b01, 64'h0000_0000_0000_0002};
        blk[2] = {2'b01, 64'h0000_0000_0000_0003};
        blk[3] = {2'b01, 64'h8000_0000_0000_0004};
        for (int i = 0; i < 3; i++) begin
            send(blk[i]);
            total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_early_valid blk=%0d got=%b want=0", i, o_valid); end
        end
        send(blk[3]);
        e_blk++; e_data++;
        exp_x = {64'h8000_0000_0000_0004, 64'h3, 64'h2, 64'h1, 1'b1};
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rst_valid got=%b want=1", o_valid); end
        total++; if (o_tx_xcoded !== exp_x) begin bad++; $display("FAIL rst_x got=%h want=%h", o_tx_xcoded, exp_x); end
        total++; if (o_block_count !== ec(e_blk) || o_data_count !== ec(e_data) || o_ctrl_count !== ec(e_ctrl)) begin bad++; $display("FAIL rst_cnt2 got=%0d/%0d/%0d want=%0d/%0d/%0d", o_block_count, o_data_count, o_ctrl_count, ec(e_blk), ec(e_data), ec(e_ctrl)); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_all_data();
        test_ctrl_first();
        test_mixed();
        test_invalid_sh();
        test_gaps();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
